// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type, S-box, rcon table and key schedule step.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned DW = 128;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10; element 0 belongs to round 1.
  localparam logic [9:0][7:0] RCON_TBL = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  // Round constant for round r (1..NR); zero outside that range.
  function automatic logic [7:0] rcon(input logic [RW-1:0] r);
    logic [7:0] v;
    v = 8'h00;
    if ((r >= 4'd1) && (r <= RW'(NR))) v = RCON_TBL[r - 4'd1];
    return v;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One AES-128 key schedule step: RotWord, SubWord, rcon XOR, then the word chain.
  function automatic logic [DW-1:0] key_expand(input logic [DW-1:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes -> ShiftRows -> (MixColumns when mix) -> AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [DW-1:0] state_in,
  input  logic [DW-1:0] rkey,
  input  logic          mix,
  output logic [DW-1:0] state_out
);

  // Byte i of the block sits at bits [127-8i -: 8]; byte 4c+r is row r, column c.
  logic [15:0][7:0] sb_c;
  logic [15:0][7:0] sr_c;
  logic [15:0][7:0] mc_c;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int unsigned ROW = i % 4;
    localparam int unsigned COL = i / 4;
    localparam int unsigned SRC = 4 * ((COL + ROW) % 4) + ROW;

    assign sb_c[i] = sbox(state_in[8*(15-i) +: 8]);
    // Row r rotates left by r columns.
    assign sr_c[i] = sb_c[SRC];
    assign state_out[8*(15-i) +: 8] = (mix ? mc_c[i] : sr_c[i]) ^ rkey[8*(15-i) +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // MixColumns with the fixed {02,03,01,01} circulant.
    assign mc_c[4*c+0] = xtime(sr_c[4*c+0]) ^ xtime(sr_c[4*c+1]) ^ sr_c[4*c+1]
                       ^ sr_c[4*c+2] ^ sr_c[4*c+3];
    assign mc_c[4*c+1] = sr_c[4*c+0] ^ xtime(sr_c[4*c+1]) ^ xtime(sr_c[4*c+2])
                       ^ sr_c[4*c+2] ^ sr_c[4*c+3];
    assign mc_c[4*c+2] = sr_c[4*c+0] ^ sr_c[4*c+1] ^ xtime(sr_c[4*c+2])
                       ^ xtime(sr_c[4*c+3]) ^ sr_c[4*c+3];
    assign mc_c[4*c+3] = xtime(sr_c[4*c+0]) ^ sr_c[4*c+0] ^ sr_c[4*c+1]
                       ^ sr_c[4*c+2] ^ xtime(sr_c[4*c+3]);
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a shared datapath,
// with the round key expanded on the fly. Define AES_ABORT_EN to add the abort input.
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
`ifdef AES_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] i_block,
  input  logic [DW-1:0] key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] o_block,
  output logic          busy,
  output logic [RW-1:0] round_o
);

  aes_fsm_e      fsm_q, fsm_d;
  logic [DW-1:0] state_q, state_d;
  logic [DW-1:0] rkey_q, rkey_d;
  logic [RW-1:0] round_q, round_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] rkey_n;
  logic [DW-1:0] dp_out;
  logic          mix;
  logic          abort_c;

`ifdef AES_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // The final round skips MixColumns.
  assign mix    = (round_q != RW'(NR));
  assign rkey_n = key_expand(rkey_q, rcon(round_q));

  aes_round_dp u_round_dp (
    .state_in  (state_q),
    .rkey      (rkey_n),
    .mix       (mix),
    .state_out (dp_out)
  );

  // Next-state, datapath register updates and registered status outputs.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;

    unique case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          fsm_d   = ROUND;
          state_d = i_block ^ key;
          rkey_d  = key;
          round_d = RW'(1);
        end
      end
      ROUND: begin
        state_d = dp_out;
        rkey_d  = rkey_n;
        if (round_q == RW'(NR)) fsm_d = DONE;
        else                    round_d = round_q + RW'(1);
      end
      DONE: begin
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase

    // Abort overrides completion and hand-off; ignored while idle.
    if (abort_c && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      rkey_d  = '0;
      round_d = '0;
    end

    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  // State, key, round and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign o_block   = state_q;
  assign round_o   = round_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Directed bench for aes128_iter_ctrl using published FIPS-197 / SP800-38A vectors
// and a ciphertext scoreboard filled on accept and drained on transfer.
module tb_aes128_iter_ctrl;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_S1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] E_S1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P_S2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] E_S2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] i_block = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] o_block;
  logic         busy;
  logic [3:0]   round_o;
`ifdef AES_ABORT_EN
  logic         abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_xfer = 0;
  int w;
  int acc0, xfer0, abase;
  logic [127:0] pend_exp = '0;
  logic [127:0] sb_q[$];
  int           acc_cyc[$];

  aes128_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_block   (i_block),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_block   (o_block),
    .busy      (busy),
    .round_o   (round_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer / accept seen before the edge, then sample 1ns after it.
  task automatic tick();
    logic acc, xfer;
    logic [127:0] ob, exp;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    ob   = o_block;
    if (xfer) begin
      n_xfer++;
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", ob);
      end
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk("sb_ciphertext", ob, exp);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      sb_q.push_back(pend_exp);
      acc_cyc.push_back(cyc);
      n_acc++;
    end
  endtask

  task automatic wait_ov(input int budget, output int waited);
    waited = 0;
    while (out_valid !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    chk("wait_out_valid", 128'(out_valid), 128'(1));
  endtask

  task automatic set_vec(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
    key      = k;
    i_block  = p;
    pend_exp = e;
  endtask

  // Single encryption with latency check and immediate hand-off.
  task automatic run_vec(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
    int lat;
    set_vec(k, p, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(20, lat);
    chk("latency", 128'(lat), 128'(10));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_xfer", 128'(in_ready), 128'(1));
    chk("ov_drop_after_xfer", 128'(out_valid), 128'(0));
  endtask

  initial begin
    // Reset values.
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round_o", 128'(round_o), 128'(0));
    chk("rst_o_block", o_block, 128'(0));
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1.
    run_vec(K_C1, P_C1, E_C1);

    // FIPS-197 B with round index trace, then 20 clk of backpressure.
    set_vec(K_B, P_B, E_B);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      chk("round_o_step", 128'(round_o), 128'(r));
      chk("busy_in_round", 128'(busy), 128'(1));
      tick();
    end
    chk("b_out_valid", 128'(out_valid), 128'(1));
    chk("b_round_o_done", 128'(round_o), 128'(10));
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_o_block", o_block, E_B);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ov_drop", 128'(out_valid), 128'(0));
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));
    chk("bp_busy_drop", 128'(busy), 128'(0));
    chk("bp_round_o_idle", 128'(round_o), 128'(0));

    // Back-to-back with in_valid held; inputs swapped right after each accept.
    acc0  = n_acc;
    xfer0 = n_xfer;
    abase = acc_cyc.size();
    out_ready = 1'b1;
    set_vec(K_B, P_S1, E_S1);
    in_valid = 1'b1;
    for (int i = 0; i < 60 && (n_xfer - xfer0) < 3; i++) begin
      tick();
      if (n_acc - acc0 == 1)      set_vec(K_B, P_S2, E_S2);
      else if (n_acc - acc0 == 2) set_vec(K_C1, P_C1, E_C1);
      else if (n_acc - acc0 >= 3) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 128'(n_acc - acc0), 128'(3));
    chk("b2b_xfers", 128'(n_xfer - xfer0), 128'(3));
    if (acc_cyc.size() >= abase + 3) begin
      chk("b2b_gap1", 128'(acc_cyc[abase+1] - acc_cyc[abase]), 128'(12));
      chk("b2b_gap2", 128'(acc_cyc[abase+2] - acc_cyc[abase+1]), 128'(12));
    end

    // Reset at round 5 discards the block; next vector still correct.
    set_vec(K_B, P_B, E_B);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_round", 128'(round_o), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_round_o", 128'(round_o), 128'(0));
    chk("mid_rst_o_block", o_block, 128'(0));
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    run_vec(K_C1, P_C1, E_C1);

`ifdef AES_ABORT_EN
    // Abort at round 7.
    set_vec(K_B, P_B, E_B);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_abort_round", 128'(round_o), 128'(7));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb_q.delete();
    chk("abort7_out_valid", 128'(out_valid), 128'(0));
    chk("abort7_round_o", 128'(round_o), 128'(0));
    chk("abort7_busy", 128'(busy), 128'(0));
    chk("abort7_in_ready", 128'(in_ready), 128'(1));
    chk("abort7_o_block", o_block, 128'(0));
    // Abort in the cycle that would complete round 10.
    set_vec(K_B, P_B, E_B);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_abort10_round", 128'(round_o), 128'(10));
    chk("pre_abort10_ov", 128'(out_valid), 128'(0));
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    chk("abort10_out_valid", 128'(out_valid), 128'(0));
    chk("abort10_round_o", 128'(round_o), 128'(0));
    for (int i = 0; i < 12; i++) begin
      chk("abort_quiet_ov", 128'(out_valid), 128'(0));
      tick();
    end
    run_vec(K_C1, P_C1, E_C1);
`endif

    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
